// File: rtl/wb_arb.sv
// ---------------------------------------------------------------------------
// wb_arb : writeback arbiter in front of the register file write port.
//
// Merges the never-stalled ALU result path with the buffered, backpressured
// load-response path onto one registered write port (we/rd/wd). Loads wait
// in a small FIFO; an ALU write to register r squashes any older buffered
// load to r so write-after-write order is preserved. The pending mask tells
// decode which registers still have a live load outstanding.
//
// Optional feature macro: WB_ARB_TRACE_EN
//   When defined, every cycle with we=1 prints its source (ALU/MEM), rd and
//   wd, and every squash prints the killed register index. When undefined no
//   simulation-only logic is present.
// ---------------------------------------------------------------------------
module wb_arb #(
    parameter int DEPTH = 2,   // load FIFO entries: 2, 4 or 8
    parameter int AW    = 4,   // register index width
    parameter int DW    = 32   // data width
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               alu_valid,
    input  logic [AW-1:0]      alu_rd,
    input  logic [DW-1:0]      alu_wd,

    input  logic               mem_valid,
    output logic               mem_ready,
    input  logic [AW-1:0]      mem_rd,
    input  logic [DW-1:0]      mem_wd,

    output logic               we,
    output logic [AW-1:0]      rd,
    output logic [DW-1:0]      wd,

    output logic [2**AW-1:0]   pending
);

    // Pointer width carries one extra wrap bit to tell full from empty.
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] vld_q,    vld_d;
    logic [DEPTH-1:0] kill_q,   kill_d;
    logic [AW-1:0]    ent_rd_q [DEPTH];
    logic [AW-1:0]    ent_rd_d [DEPTH];
    logic [DW-1:0]    ent_wd_q [DEPTH];
    logic [DW-1:0]    ent_wd_d [DEPTH];

    logic             we_q, we_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [DW-1:0]    wd_q, wd_d;

    // -----------------------------------------------------------------------
    // Decode of the current cycle
    // -----------------------------------------------------------------------
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] hd_idx;
    logic          full;
    logic          empty;
    logic          alu_sel;     // ALU write wins the port this cycle
    logic          head_live;   // head entry present and not squashed
    logic          head_dead;   // head entry present but squashed
    logic          push;
    logic          pop;

    assign wr_idx = wr_ptr_q[IW-1:0];
    assign hd_idx = rd_ptr_q[IW-1:0];
    assign full   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_idx == hd_idx);
    assign empty  = (wr_ptr_q == rd_ptr_q);

    // Backpressure depends on stored state only, never on mem_valid or on a
    // same-cycle pop, so there is no combinational path through this block.
    assign mem_ready = !full;

    // Classify this cycle: who owns the port, and whether the FIFO moves.
    always_comb begin
        // NOTE: every signal written here gets a value on every path first,
        // otherwise synthesis infers a latch to hold the missing case.
        alu_sel   = 1'b0;
        head_live = 1'b0;
        head_dead = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;

        alu_sel   = alu_valid && (alu_rd != '0);
        head_live = !empty && !kill_q[hd_idx];
        head_dead = !empty &&  kill_q[hd_idx];

        // Loads to x0 are accepted but dropped: they never take a slot.
        push = mem_valid && mem_ready && (mem_rd != '0);

        // At most one pop per cycle, and only when the ALU is not writing.
        pop  = !alu_sel && (head_live || head_dead);
    end

    // -----------------------------------------------------------------------
    // FIFO next state: squash, pop, push
    // -----------------------------------------------------------------------

    // Apply squash to older matching entries, then retire the head, then
    // append the new load with kill clear so a same-cycle load survives.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;
        kill_d   = kill_q;
        ent_rd_d = ent_rd_q;
        ent_wd_d = ent_wd_q;

        if (alu_sel) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && (ent_rd_q[i] == alu_rd)) begin
                    kill_d[i] = 1'b1;
                end
            end
        end

        if (pop) begin
            vld_d[hd_idx]  = 1'b0;
            kill_d[hd_idx] = 1'b0;
            rd_ptr_d       = rd_ptr_q + PW'(1);
        end

        // The tail slot is never the head being popped: a push needs
        // !full and a pop needs !empty, so the indices differ whenever
        // both happen in one cycle.
        if (push) begin
            vld_d[wr_idx]    = 1'b1;
            kill_d[wr_idx]   = 1'b0;
            ent_rd_d[wr_idx] = mem_rd;
            ent_wd_d[wr_idx] = mem_wd;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Write port next state
    // -----------------------------------------------------------------------

    // ALU first, then a live head; otherwise we drops and rd/wd hold.
    always_comb begin
        we_d = 1'b0;
        rd_d = rd_q;
        wd_d = wd_q;

        if (alu_sel) begin
            we_d = 1'b1;
            rd_d = alu_rd;
            wd_d = alu_wd;
        end else if (head_live) begin
            we_d = 1'b1;
            rd_d = ent_rd_q[hd_idx];
            wd_d = ent_wd_q[hd_idx];
        end
    end

    // -----------------------------------------------------------------------
    // Pending mask
    // -----------------------------------------------------------------------

    // One bit per register that still has a live (unsquashed) load queued.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && !kill_q[i]) begin
                pending[ent_rd_q[i]] = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------

    // Control state and the write port; reset discards in-flight loads.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples the pre-edge value regardless of statement order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            vld_q    <= '0;
            kill_q   <= '0;
            we_q     <= 1'b0;
            rd_q     <= '0;
            wd_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            vld_q    <= vld_d;
            kill_q   <= kill_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            wd_q     <= wd_d;
        end
    end

    // Entry payload storage.
    always_ff @(posedge clk) begin
        // NOTE: payload is deliberately not reset; the valid bits gate every
        // read of it, so clearing the array would only cost reset fan-out.
        ent_rd_q <= ent_rd_d;
        ent_wd_q <= ent_wd_d;
    end

    assign we = we_q;
    assign rd = rd_q;
    assign wd = wd_q;

`ifdef WB_ARB_TRACE_EN
    // -----------------------------------------------------------------------
    // Trace: remembers which source produced the registered write.
    // -----------------------------------------------------------------------
    logic src_alu_q, src_alu_d;

    assign src_alu_d = alu_sel;

    // Track the source alongside we_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_alu_q <= 1'b0;
        end else begin
            src_alu_q <= src_alu_d;
        end
    end

    // Report port writes and squashes as they happen.
    always_ff @(posedge clk) begin
        if (we_q) begin
            $display("[wb_arb] %0t write %s x%0d = %h",
                     $time, src_alu_q ? "ALU" : "MEM", rd_q, wd_q);
        end
        if (!rst && alu_sel) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && !kill_q[i] && (ent_rd_q[i] == alu_rd)) begin
                    $display("[wb_arb] %0t squash x%0d (slot %0d)",
                             $time, ent_rd_q[i], i);
                end
            end
        end
    end
`else
`endif

endmodule
